tbp_resolve_unit: RTL and testbench
===================================

// Module: tbp_resolve_unit
// PURPOSE
//  Resolution-side producer for the tournament branch predictor update port (pc_res/taken_res/enable_res).
//  - Records each fetched conditional branch's PC and both component predictions in an in-order FIFO.
//  - On execute resolution, pops the oldest entry and scores each component predictor against the outcome.
//  - Drives one registered update per resolved branch toward the predictor tables.
// PARAMETERS
//  DEPTH  4   in-flight branch entries (power of 2, >=2)
//  PC_W   32  PC width (matches word_t)
// PORTS
//  CLK         in   1           clock, all state on rising edge
//  nRST        in   1           async active-low reset
//  fetch_valid in   1           fetch issued a predicted conditional branch this cycle
//  fetch_pc    in   PC_W        PC of that branch
//  fetch_p1    in   1           predictor 1 direction (1=taken)
//  fetch_p2    in   1           predictor 2 direction (1=taken)
//  full        out  1           FIFO holds DEPTH entries; fetch must stall
//  ex_valid    in   1           oldest in-flight branch resolved this cycle
//  ex_pc       in   PC_W        PC of resolving branch
//  ex_taken    in   1           actual outcome
//  flush       in   1           pipeline redirect; all younger branches are wrong-path
//  pc_res      out  PC_W        PC of updated branch
//  taken_res   out  2           {p1 correct, p2 correct}; bit=1 when that predictor matched ex_taken
//  enable_res  out  1           update strobe, one cycle per update
//  count       out  $clog2(DEPTH+1)  occupancy
//  err         out  3           sticky {mismatch, underflow, overflow}
// BEHAVIOUR
//  Reset: FIFO empty, count=0, full=0, pc_res=0, taken_res=0, enable_res=0, err=0. Asynchronous, mid-operation included.
//  Push: fetch_valid & (!full | pop) writes {fetch_pc,p1,p2} at tail.
//  Overflow: fetch_valid & full & !pop drops the entry and sets err[0].
//  Pop: ex_valid & count!=0 reads head.
//  Underflow: ex_valid & count==0 produces no update and sets err[1].
//  Pop when full frees the slot the same cycle: simultaneous push+pop at count=DEPTH is legal; count stays DEPTH.
//  Push+pop at count=0: no bypass. Pop underflows; push completes; count=1.
//  Pointers wrap modulo DEPTH. count = pushes - pops. full = (count==DEPTH), combinational from count.
//  Latency: update registered 1 cycle after the pop edge.
//    pc_res <= head.pc; taken_res <= {head.p1~^ex_taken, head.p2~^ex_taken}; enable_res <= 1.
//    enable_res is 0 in every cycle without a qualifying pop.
//    pc_res/taken_res hold their last value while enable_res=0.
//  Mismatch: ex_pc != head.pc still pops the entry, but enable_res stays 0 and err[2] is set.
//  Flush: the same-cycle ex_valid pop and update are performed first (the redirecting branch itself resolves).
//    Then every remaining entry is discarded: count=0, head=tail=0 after the edge.
//    A same-cycle push is discarded, with no overflow flag.
//  err bits are sticky until nRST.
// CONFIGURATION
//  TBP_DISAGREE_FILTER_EN
//    Defined: enable_res is asserted only when taken_res is 2'b10 or 2'b01 (component predictors disagreed).
//      Agreeing pops (2'b11/2'b00) still pop but leave enable_res=0 and pc_res/taken_res unchanged.
//    Undefined: every valid non-mismatch pop asserts enable_res.
// TESTING
//  1. Reset: nRST=0 mid-stream with count=3 -> all outputs 0 immediately; count=0 after release.
//  2. Single branch: push pc=0x100 p1=1 p2=0, then ex_valid pc=0x100 taken=1
//     -> next cycle enable_res=1, pc_res=0x100, taken_res=2'b10.
//  3. Fill/wrap: 4 pushes -> full=1; 5th push alone sets err[0], count=4.
//     Push+pop at full -> count=4, no err. Drain 4 -> PCs in order, wrap correct.
//  4. Flush: 3 entries, ex_valid on head with flush=1 plus a push
//     -> one update for head, count=0 next cycle, pushed PC never appears.
//  5. Errors: ex_valid on empty -> err[1], enable_res=0.
//     Head pc=0x200 vs ex_pc=0x204 -> entry popped, enable_res=0, err[2]=1.
//  6. Filter: with TBP_DISAGREE_FILTER_EN, p1=p2=1 taken=0 -> pop, enable_res=0.
//     Without the macro -> enable_res=1, taken_res=2'b00.

Source files
------------

// File: rtl/tbp_resolve_unit_if.sv
// Handshake and result bundle for the tournament predictor resolve unit.
// Latency: none (wires only).
// Backpressure: full is exported here; fetch must stall while it is high.
interface tbp_resolve_unit_if #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              fetch_valid;
   logic [PC_W-1:0]   fetch_pc;
   logic              fetch_p1;
   logic              fetch_p2;
   logic              full;
   logic              ex_valid;
   logic [PC_W-1:0]   ex_pc;
   logic              ex_taken;
   logic              flush;
   logic [PC_W-1:0]   pc_res;
   logic [1:0]        taken_res;
   logic              enable_res;
   logic [CNT_W-1:0]  count;
   logic [2:0]        err;

   // Pipeline side: issues fetch/resolve events, observes updates.
   modport master (
      output fetch_valid, fetch_pc, fetch_p1, fetch_p2,
      output ex_valid, ex_pc, ex_taken, flush,
      input  full, pc_res, taken_res, enable_res, count, err
   );

   // Resolve unit side.
   modport slave (
      input  fetch_valid, fetch_pc, fetch_p1, fetch_p2,
      input  ex_valid, ex_pc, ex_taken, flush,
      output full, pc_res, taken_res, enable_res, count, err
   );
endinterface

// File: rtl/tbp_resolve_unit.sv
// Tracks in-flight branches in order, scores both component predictors at resolve, drives table update.
// Latency: update registered one cycle after the popping edge; full/count visible combinationally from state.
// Backpressure: full stalls fetch (push allowed at full only with a same-cycle pop); option TBP_DISAGREE_FILTER_EN.
module tbp_resolve_unit #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input logic              CLK,
   input logic              nRST,
   tbp_resolve_unit_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            p1;
      logic            p2;
   } entry_t;

   entry_t            mem [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count_q;
   logic [PC_W-1:0]   pc_q;
   logic [1:0]        taken_q;
   logic              enable_q;
   logic [2:0]        err_q;

   logic   is_full;
   logic   is_empty;
   logic   pop;
   logic   push;
   logic   overflow;
   logic   underflow;
   logic   mismatch;
   logic   p1_ok;
   logic   p2_ok;
   logic   update;
   entry_t head_e;

   // Decode this cycle's push/pop/error events from state and inputs.
   always_comb begin
      is_full   = (count_q == CNT_W'(DEPTH));
      is_empty  = (count_q == '0);
      head_e    = mem[head];
      pop       = bus.ex_valid & ~is_empty;
      // Flush discards a same-cycle push, so it can neither enqueue nor overflow.
      push      = bus.fetch_valid & (~is_full | pop) & ~bus.flush;
      overflow  = bus.fetch_valid & is_full & ~pop & ~bus.flush;
      underflow = bus.ex_valid & is_empty;
      mismatch  = pop & (bus.ex_pc != head_e.pc);
      p1_ok     = head_e.p1 ~^ bus.ex_taken;
      p2_ok     = head_e.p2 ~^ bus.ex_taken;
`ifdef TBP_DISAGREE_FILTER_EN
      // Only disagreeing predictions train the chooser, so agreeing pops are silent.
      update    = pop & ~mismatch & (p1_ok ^ p2_ok);
`else
      update    = pop & ~mismatch;
`endif
   end

   // Entry storage; contents are only meaningful between head and tail, so no reset.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[tail] <= '{pc: bus.fetch_pc, p1: bus.fetch_p1, p2: bus.fetch_p2};
      end
   end

   // Pointer and occupancy tracking; flush empties the queue after the head pop.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else if (bus.flush) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Registered update toward the predictor tables; data holds while idle.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pc_q     <= '0;
         taken_q  <= '0;
         enable_q <= 1'b0;
      end else begin
         enable_q <= update;
         if (update) begin
            pc_q    <= head_e.pc;
            taken_q <= {p1_ok, p2_ok};
         end
      end
   end

   // Sticky error flags {mismatch, underflow, overflow}.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         err_q <= '0;
      end else begin
         err_q <= err_q | {mismatch, underflow, overflow};
      end
   end

   assign bus.full       = is_full;
   assign bus.count      = count_q;
   assign bus.pc_res     = pc_q;
   assign bus.taken_res  = taken_q;
   assign bus.enable_res = enable_q;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_tbp_resolve_unit.sv
// Directed bench for tbp_resolve_unit: expected updates go to a scoreboard queue,
// a negedge monitor pops and compares each enable_res pulse; state is checked inline.
module tb_tbp_resolve_unit;
   logic CLK;
   logic nRST;

   tbp_resolve_unit_if #(.DEPTH(4), .PC_W(32)) bus ();

   tbp_resolve_unit #(.DEPTH(4), .PC_W(32)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_pass  = 0;
   int n_total = 0;
   logic [33:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Scoreboard monitor: every update pulse must match the oldest expectation.
   always @(negedge CLK) begin
      if (nRST === 1'b1 && bus.enable_res !== 1'b0) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_update: got pc 0x%0h taken %b, expected no update at %0t",
                     bus.pc_res, bus.taken_res, $time);
         end else begin
            logic [33:0] e;
            e = exp_q.pop_front();
            check("upd_pc", bus.pc_res, e[33:2]);
            check("upd_taken", {30'd0, bus.taken_res}, {30'd0, e[1:0]});
         end
      end
   end

   task automatic step(input logic fv, input logic [31:0] fpc, input logic p1, input logic p2,
                       input logic ev, input logic [31:0] epc, input logic et, input logic fl);
      bus.fetch_valid = fv;
      bus.fetch_pc    = fpc;
      bus.fetch_p1    = p1;
      bus.fetch_p2    = p2;
      bus.ex_valid    = ev;
      bus.ex_pc       = epc;
      bus.ex_taken    = et;
      bus.flush       = fl;
      @(posedge CLK);
      #1;
      bus.fetch_valid = 1'b0;
      bus.ex_valid    = 1'b0;
      bus.flush       = 1'b0;
   endtask

   task automatic push(input logic [31:0] pc, input logic p1, input logic p2);
      step(1'b1, pc, p1, p2, 1'b0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic pop(input logic [31:0] pc, input logic t);
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, pc, t, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
   endtask

   initial begin
      bus.fetch_valid = 1'b0;
      bus.fetch_pc    = '0;
      bus.fetch_p1    = 1'b0;
      bus.fetch_p2    = 1'b0;
      bus.ex_valid    = 1'b0;
      bus.ex_pc       = '0;
      bus.ex_taken    = 1'b0;
      bus.flush       = 1'b0;
      nRST = 1'b0;
      #2;
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_full", 32'(bus.full), 32'd0);
      check("rst_enable", 32'(bus.enable_res), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      #10 nRST = 1'b1;
      @(posedge CLK); #1;

      // Underflow on empty, then build count=3 with a live update before an async reset.
      pop(32'h10, 1'b1);
      check("unf_err", 32'(bus.err), 32'h2);
      push(32'h10, 1'b1, 1'b0);
      push(32'h14, 1'b1, 1'b0);
      push(32'h18, 1'b1, 1'b0);
      push(32'h1C, 1'b1, 1'b0);
      exp_q.push_back({32'h10, 2'b10});
      pop(32'h10, 1'b1);
      check("pre_rst_count", 32'(bus.count), 32'd3);
      @(negedge CLK); #1;
      nRST = 1'b0;
      #1;
      check("mid_rst_enable", 32'(bus.enable_res), 32'd0);
      check("mid_rst_pc", bus.pc_res, 32'd0);
      check("mid_rst_taken", 32'(bus.taken_res), 32'd0);
      check("mid_rst_err", 32'(bus.err), 32'd0);
      check("mid_rst_count", 32'(bus.count), 32'd0);
      #2 nRST = 1'b1;
      idle();
      check("post_rst_count", 32'(bus.count), 32'd0);

      // Single branch round trip.
      push(32'h100, 1'b1, 1'b0);
      exp_q.push_back({32'h100, 2'b10});
      pop(32'h100, 1'b1);
      check("single_count", 32'(bus.count), 32'd0);

      // Fill, overflow, push+pop at full, drain across the wrap.
      push(32'h200, 1'b0, 1'b1);
      push(32'h204, 1'b0, 1'b1);
      push(32'h208, 1'b0, 1'b1);
      push(32'h20C, 1'b0, 1'b1);
      check("fill_full", 32'(bus.full), 32'd1);
      check("fill_count", 32'(bus.count), 32'd4);
      push(32'h210, 1'b0, 1'b1);
      check("ovf_err", 32'(bus.err), 32'h1);
      check("ovf_count", 32'(bus.count), 32'd4);
      exp_q.push_back({32'h200, 2'b10});
      step(1'b1, 32'h214, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
      check("pp_full_count", 32'(bus.count), 32'd4);
      check("pp_full_err", 32'(bus.err), 32'h1);
      exp_q.push_back({32'h204, 2'b01});
      pop(32'h204, 1'b1);
      exp_q.push_back({32'h208, 2'b01});
      pop(32'h208, 1'b1);
      exp_q.push_back({32'h20C, 2'b01});
      pop(32'h20C, 1'b1);
      exp_q.push_back({32'h214, 2'b01});
      pop(32'h214, 1'b1);
      check("drain_count", 32'(bus.count), 32'd0);

      // Flush with head resolve and a discarded push; then prove pointers restarted at 0.
      push(32'h300, 1'b1, 1'b0);
      push(32'h304, 1'b1, 1'b0);
      push(32'h308, 1'b1, 1'b0);
      exp_q.push_back({32'h300, 2'b01});
      step(1'b1, 32'h30C, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 1'b1);
      check("flush_count", 32'(bus.count), 32'd0);
      check("flush_err", 32'(bus.err), 32'h1);
      idle();
      push(32'h310, 1'b1, 1'b0);
      exp_q.push_back({32'h310, 2'b10});
      pop(32'h310, 1'b1);
      check("post_flush_count", 32'(bus.count), 32'd0);

      // Underflow and PC mismatch.
      pop(32'h500, 1'b0);
      check("unf2_err", 32'(bus.err), 32'h3);
      push(32'h200, 1'b1, 1'b0);
      pop(32'h204, 1'b1);
      check("mism_err", 32'(bus.err), 32'h7);
      check("mism_count", 32'(bus.count), 32'd0);

      // Agreeing predictors, both wrong.
      push(32'h400, 1'b1, 1'b1);
`ifndef TBP_DISAGREE_FILTER_EN
      exp_q.push_back({32'h400, 2'b00});
`endif
      pop(32'h400, 1'b0);
      check("agree_count", 32'(bus.count), 32'd0);

      idle();
      idle();
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
